conv_stream_ctrl: RTL and testbench

CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

---
 rtl/conv_stream_ctrl.sv | 130 +++++++++++++
 tb/tb_conv_stream_ctrl.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl
// Streams one captured convolution window into a vertical stack of CIM
// crossbar tiles, one row per cycle, then requests a compute and waits for
// the tiles to accept it before signalling completion.
module conv_stream_ctrl #(
    parameter int datatype_size  = 8,
    parameter int input_channels = 5,
    parameter int kernel_dim     = 3,
    parameter int xbar_size      = 256,
    parameter int input_size     = input_channels * kernel_dim ** 2,
    parameter int v_cim_tiles    = (input_size + xbar_size - 1) / xbar_size
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [datatype_size-1:0]     i_data [input_size],
    input  logic                         i_cim_busy,
    input  logic                         i_func_busy,
    output logic                         o_busy,
    output logic [v_cim_tiles-1:0]       o_cim_we,
    output logic [$clog2(xbar_size)-1:0] o_cim_addr,
    output logic [datatype_size-1:0]     o_data [v_cim_tiles],
    output logic                         o_cim_start,
    output logic                         o_done
);

    localparam int AW        = $clog2(xbar_size);
    localparam int IW        = (input_size > 1) ? $clog2(input_size) : 1;
    localparam int ROW_LIMIT = (input_size < xbar_size) ? input_size : xbar_size;
    localparam logic [AW-1:0] LAST_ROW = AW'(ROW_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CIM = 2'd1,
        LOAD     = 2'd2,
        FIRE     = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [AW-1:0]            r_row;
    logic [AW-1:0]            w_row_nxt;
    logic [datatype_size-1:0] r_buf [input_size];
    logic                     w_capture;
    logic                     w_write;

    // State and row counter; async reset abandons any window in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Window snapshot; contents only matter after a capture, so no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= i_data;
        end
    end

    // Next-state, row advance and Mealy control outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_capture   = 1'b0;
        w_write     = 1'b0;
        o_busy      = (r_state != IDLE);
        o_cim_start = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WAIT_CIM;
                end
            end
            WAIT_CIM: begin
                if (!i_cim_busy) begin
                    w_row_nxt   = '0;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                // A busy tile stalls the row: nothing written, counter held.
                if (!i_cim_busy) begin
                    w_write = 1'b1;
                    if (r_row == LAST_ROW) begin
                        w_row_nxt   = '0;
                        w_state_nxt = FIRE;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end
            FIRE: begin
                o_cim_start = !i_func_busy;
                // Tiles going busy while the function unit is free means
                // the compute request was taken.
                if (i_cim_busy && !i_func_busy) begin
                    o_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_row_nxt   = '0;
            end
        endcase
    end

    assign o_cim_addr = (r_state == LOAD) ? r_row : '0;

    // Tile t holds window elements [t*xbar_size, (t+1)*xbar_size); the last
    // tile may be partially filled, so its upper rows are masked off.
    for (genvar t = 0; t < v_cim_tiles; t++) begin : g_tile
        logic [31:0] w_sum;
        logic        w_in_range;

        assign w_sum       = 32'(r_row) + 32'(t * xbar_size);
        assign w_in_range  = (w_sum < 32'(input_size));
        assign o_cim_we[t] = w_write & w_in_range;
        assign o_data[t]   = ((r_state == LOAD) && w_in_range) ? r_buf[IW'(w_sum)]
                                                                : '0;
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl: default geometry (45 elements, one
// tile) plus a 64-channel instance (576 elements over three tiles).
module tb_conv_stream_ctrl;

    localparam int N  = 45;
    localparam int BN = 576;
    localparam int BT = 3;

    logic       clk;
    logic       rst;

    logic       s_start;
    logic [7:0] s_data [N];
    logic       s_cim_busy;
    logic       s_func_busy;
    logic       s_busy;
    logic [0:0] s_we;
    logic [7:0] s_addr;
    logic [7:0] s_odata [1];
    logic       s_cstart;
    logic       s_done;

    logic          b_start;
    logic [7:0]    b_data [BN];
    logic          b_cim_busy;
    logic          b_func_busy;
    logic          b_busy;
    logic [BT-1:0] b_we;
    logic [7:0]    b_addr;
    logic [7:0]    b_odata [BT];
    logic          b_cstart;
    logic          b_done;

    int tests;
    int fails;

    conv_stream_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (s_start),
        .i_data      (s_data),
        .i_cim_busy  (s_cim_busy),
        .i_func_busy (s_func_busy),
        .o_busy      (s_busy),
        .o_cim_we    (s_we),
        .o_cim_addr  (s_addr),
        .o_data      (s_odata),
        .o_cim_start (s_cstart),
        .o_done      (s_done)
    );

    conv_stream_ctrl #(
        .datatype_size  (8),
        .input_channels (64),
        .kernel_dim     (3),
        .xbar_size      (256)
    ) dut_big (
        .clk         (clk),
        .rst         (rst),
        .i_start     (b_start),
        .i_data      (b_data),
        .i_cim_busy  (b_cim_busy),
        .i_func_busy (b_func_busy),
        .o_busy      (b_busy),
        .o_cim_we    (b_we),
        .o_cim_addr  (b_addr),
        .o_data      (b_odata),
        .o_cim_start (b_cstart),
        .o_done      (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_start = 1'b0; s_cim_busy = 1'b0; s_func_busy = 1'b0;
        b_start = 1'b0; b_cim_busy = 1'b0; b_func_busy = 1'b0;
        for (int k = 0; k < N; k++) s_data[k] = '0;
        for (int k = 0; k < BN; k++) b_data[k] = '0;
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({s_busy, s_we, s_addr, s_cstart, s_done} !== 12'h000) begin
            $display("FAIL reset_async: got %h expected 000", {s_busy, s_we, s_addr, s_cstart, s_done});
            fails++;
        end
        tests++;
        if ({b_busy, b_we, b_addr, b_cstart, b_done} !== 14'h0000) begin
            $display("FAIL reset_async_big: got %h expected 0000", {b_busy, b_we, b_addr, b_cstart, b_done});
            fails++;
        end
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++;
        if (s_busy !== 1'b0 || s_we !== 1'b0 || s_addr !== 8'd0) begin
            $display("FAIL reset_release: busy=%b we=%b addr=%0d expected 0 0 0", s_busy, s_we, s_addr);
            fails++;
        end
    endtask

    // Full unstalled window on the default instance; also pins the 2-cycle
    // start-to-first-write latency and the 45-row write span.
    task automatic test_basic();
        logic [7:0] snap [N];
        for (int k = 0; k < N; k++) begin
            s_data[k] = 8'(k * 3 + 1);
            snap[k]   = 8'(k * 3 + 1);
        end
        s_cim_busy = 1'b0; s_func_busy = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        #1;
        tests++;
        if (s_busy !== 1'b1 || s_we !== 1'b0 || s_addr !== 8'd0) begin
            $display("FAIL basic_wait: busy=%b we=%b addr=%0d expected 1 0 0", s_busy, s_we, s_addr);
            fails++;
        end
        tick();
        for (int a = 0; a < N; a++) begin
            #1;
            tests++;
            if (s_we !== 1'b1 || s_addr !== 8'(a)) begin
                $display("FAIL basic_row: row %0d we=%b addr=%0d expected we=1 addr=%0d", a, s_we, s_addr, a);
                fails++;
            end
            tests++;
            if (s_odata[0] !== snap[a]) begin
                $display("FAIL basic_data: row %0d got %h expected %h", a, s_odata[0], snap[a]);
                fails++;
            end
            tick();
        end
        #1;
        tests++;
        if (s_busy !== 1'b1 || s_we !== 1'b0 || s_addr !== 8'd0 || s_cstart !== 1'b1 || s_done !== 1'b0) begin
            $display("FAIL basic_fire: busy=%b we=%b addr=%0d start=%b done=%b expected 1 0 0 1 0",
                     s_busy, s_we, s_addr, s_cstart, s_done);
            fails++;
        end
        s_cim_busy = 1'b1;
        #1;
        tests++;
        if (s_done !== 1'b1) begin
            $display("FAIL basic_done: got %b expected 1", s_done);
            fails++;
        end
        tick();
        s_cim_busy = 1'b0;
        #1;
        tests++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_cstart !== 1'b0) begin
            $display("FAIL basic_idle: busy=%b done=%b start=%b expected 0 0 0", s_busy, s_done, s_cstart);
            fails++;
        end
    endtask

    // Three-tile instance: tile 2 only holds elements 512..575 (rows 0..63).
    task automatic test_wide();
        logic [7:0]    snap [BN];
        logic [BT-1:0] exp_we;
        logic [7:0]    exp_d;
        int            idx;
        for (int k = 0; k < BN; k++) begin
            b_data[k] = 8'(k * 7 + 3);
            snap[k]   = 8'(k * 7 + 3);
        end
        b_cim_busy = 1'b0; b_func_busy = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        for (int a = 0; a < 256; a++) begin
            #1;
            for (int t = 0; t < BT; t++) exp_we[t] = (a + t * 256 < BN);
            tests++;
            if (b_we !== exp_we || b_addr !== 8'(a)) begin
                $display("FAIL wide_row: row %0d we=%b addr=%0d expected we=%b addr=%0d", a, b_we, b_addr, exp_we, a);
                fails++;
            end
            for (int t = 0; t < BT; t++) begin
                idx   = a + t * 256;
                exp_d = (idx < BN) ? snap[idx] : 8'h00;
                tests++;
                if (b_odata[t] !== exp_d) begin
                    $display("FAIL wide_data: row %0d tile %0d got %h expected %h", a, t, b_odata[t], exp_d);
                    fails++;
                end
            end
            if (a == 63) begin
                tests++;
                if (b_we !== 3'b111) begin
                    $display("FAIL wide_row63: we got %b expected 111", b_we);
                    fails++;
                end
            end
            if (a == 64) begin
                tests++;
                if (b_we !== 3'b011 || b_odata[2] !== 8'h00) begin
                    $display("FAIL wide_row64: we=%b data2=%h expected 011 00", b_we, b_odata[2]);
                    fails++;
                end
            end
            tick();
        end
        #1;
        tests++;
        if (b_we !== 3'b000 || b_cstart !== 1'b1 || b_busy !== 1'b1) begin
            $display("FAIL wide_fire: we=%b start=%b busy=%b expected 000 1 1", b_we, b_cstart, b_busy);
            fails++;
        end
        b_cim_busy = 1'b1;
        #1;
        tests++;
        if (b_done !== 1'b1) begin
            $display("FAIL wide_done: got %b expected 1", b_done);
            fails++;
        end
        tick();
        b_cim_busy = 1'b0;
        #1;
        tests++;
        if (b_busy !== 1'b0) begin
            $display("FAIL wide_idle: busy got %b expected 0", b_busy);
            fails++;
        end
    endtask

    // Three busy cycles at row 10: writes suppressed, address held, no row lost.
    task automatic test_stall();
        logic [7:0] snap [N];
        int a;
        int stall_left;
        for (int k = 0; k < N; k++) begin
            s_data[k] = 8'(200 - k);
            snap[k]   = 8'(200 - k);
        end
        s_cim_busy = 1'b0; s_func_busy = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        a = 0;
        stall_left = 3;
        for (int c = 0; c < 60 && a < N; c++) begin
            if (a == 10 && stall_left > 0) begin
                s_cim_busy = 1'b1;
                #1;
                tests++;
                if (s_we !== 1'b0 || s_addr !== 8'd10) begin
                    $display("FAIL stall_hold: cycle %0d we=%b addr=%0d expected 0 10", c, s_we, s_addr);
                    fails++;
                end
                stall_left--;
            end else begin
                s_cim_busy = 1'b0;
                #1;
                tests++;
                if (s_we !== 1'b1 || s_addr !== 8'(a) || s_odata[0] !== snap[a]) begin
                    $display("FAIL stall_row: row %0d we=%b addr=%0d data=%h expected 1 %0d %h",
                             a, s_we, s_addr, s_odata[0], a, snap[a]);
                    fails++;
                end
                a++;
            end
            tick();
        end
        s_cim_busy = 1'b0;
        #1;
        tests++;
        if (a != N || s_cstart !== 1'b1 || s_we !== 1'b0) begin
            $display("FAIL stall_fire: rows=%0d start=%b we=%b expected %0d 1 0", a, s_cstart, s_we, N);
            fails++;
        end
        s_cim_busy = 1'b1;
        #1;
        tests++;
        if (s_done !== 1'b1) begin
            $display("FAIL stall_done: got %b expected 1", s_done);
            fails++;
        end
        tick();
        s_cim_busy = 1'b0;
    endtask

    // Function unit busy on FIRE entry holds off the compute request and done.
    task automatic test_fire_wait();
        for (int k = 0; k < N; k++) s_data[k] = 8'(k);
        s_cim_busy = 1'b0; s_func_busy = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        for (int a = 0; a < N; a++) begin
            if (a == N - 1) s_func_busy = 1'b1;
            #1;
            tests++;
            if (s_addr !== 8'(a) || s_we !== 1'b1) begin
                $display("FAIL fire_load: row %0d addr=%0d we=%b expected %0d 1", a, s_addr, s_we, a);
                fails++;
            end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            s_cim_busy = (c >= 3);
            #1;
            tests++;
            if (s_cstart !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b1) begin
                $display("FAIL fire_hold: cycle %0d start=%b done=%b busy=%b expected 0 0 1",
                         c, s_cstart, s_done, s_busy);
                fails++;
            end
            tick();
        end
        s_func_busy = 1'b0;
        s_cim_busy  = 1'b0;
        #1;
        tests++;
        if (s_cstart !== 1'b1 || s_done !== 1'b0) begin
            $display("FAIL fire_req: start=%b done=%b expected 1 0", s_cstart, s_done);
            fails++;
        end
        tick();
        s_cim_busy = 1'b1;
        #1;
        tests++;
        if (s_done !== 1'b1 || s_cstart !== 1'b1) begin
            $display("FAIL fire_done: done=%b start=%b expected 1 1", s_done, s_cstart);
            fails++;
        end
        tick();
        s_cim_busy = 1'b0;
        #1;
        tests++;
        if (s_busy !== 1'b0 || s_done !== 1'b0) begin
            $display("FAIL fire_idle: busy=%b done=%b expected 0 0", s_busy, s_done);
            fails++;
        end
    endtask

    // Input scrambled every cycle and a stray start during LOAD.
    task automatic test_snapshot();
        logic [7:0] snap [N];
        for (int k = 0; k < N; k++) begin
            s_data[k] = 8'(k * 5 + 9);
            snap[k]   = 8'(k * 5 + 9);
        end
        s_cim_busy = 1'b0; s_func_busy = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 0; k < N; k++) s_data[k] = 8'($urandom);
        tick();
        for (int a = 0; a < N; a++) begin
            for (int k = 0; k < N; k++) s_data[k] = 8'($urandom);
            s_start = (a == 5);
            #1;
            tests++;
            if (s_addr !== 8'(a) || s_odata[0] !== snap[a]) begin
                $display("FAIL snap_row: row %0d addr=%0d data=%h expected %0d %h", a, s_addr, s_odata[0], a, snap[a]);
                fails++;
            end
            tick();
        end
        s_start = 1'b0;
        s_cim_busy = 1'b1;
        #1;
        tests++;
        if (s_done !== 1'b1) begin
            $display("FAIL snap_done: got %b expected 1", s_done);
            fails++;
        end
        tick();
        s_cim_busy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (s_busy !== 1'b0) begin
                $display("FAIL snap_ignored_start: cycle %0d busy=%b expected 0", c, s_busy);
                fails++;
            end
            tick();
        end
    endtask

    // Reset between edges in the middle of LOAD, then a clean window.
    task automatic test_reset_mid();
        logic [7:0] snap [N];
        for (int k = 0; k < N; k++) s_data[k] = 8'(k + 100);
        s_cim_busy = 1'b0; s_func_busy = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        for (int a = 0; a < 7; a++) tick();
        #2;
        tests++;
        if (s_addr !== 8'd7 || s_we !== 1'b1) begin
            $display("FAIL rmid_pre: addr=%0d we=%b expected 7 1", s_addr, s_we);
            fails++;
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({s_busy, s_we, s_addr, s_cstart, s_done} !== 12'h000 || s_odata[0] !== 8'h00) begin
            $display("FAIL rmid_async: outs=%h data=%h expected 000 00",
                     {s_busy, s_we, s_addr, s_cstart, s_done}, s_odata[0]);
            fails++;
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            s_data[k] = 8'(255 - k);
            snap[k]   = 8'(255 - k);
        end
        #1;
        tests++;
        if (s_busy !== 1'b0) begin
            $display("FAIL rmid_idle: busy=%b expected 0", s_busy);
            fails++;
        end
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        for (int a = 0; a < N; a++) begin
            #1;
            tests++;
            if (s_addr !== 8'(a) || s_we !== 1'b1 || s_odata[0] !== snap[a]) begin
                $display("FAIL rmid_row: row %0d addr=%0d we=%b data=%h expected %0d 1 %h",
                         a, s_addr, s_we, s_odata[0], a, snap[a]);
                fails++;
            end
            tick();
        end
        s_cim_busy = 1'b1;
        #1;
        tests++;
        if (s_done !== 1'b1) begin
            $display("FAIL rmid_done: got %b expected 1", s_done);
            fails++;
        end
        tick();
        s_cim_busy = 1'b0;
    endtask

    // Second window started in the cycle right after the done pulse.
    task automatic test_back_to_back();
        logic [7:0] snap [N];
        for (int k = 0; k < N; k++) s_data[k] = 8'(k + 50);
        s_cim_busy = 1'b0; s_func_busy = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < N; k++) snap[k] = 8'(k + 50 + w * 50);
            for (int a = 0; a < N; a++) begin
                #1;
                tests++;
                if (s_addr !== 8'(a) || s_odata[0] !== snap[a]) begin
                    $display("FAIL b2b_row: win %0d row %0d addr=%0d data=%h expected %0d %h",
                             w, a, s_addr, s_odata[0], a, snap[a]);
                    fails++;
                end
                tick();
            end
            s_cim_busy = 1'b1;
            s_start = (w == 0);
            #1;
            tests++;
            if (s_done !== 1'b1) begin
                $display("FAIL b2b_done: win %0d got %b expected 1", w, s_done);
                fails++;
            end
            tick();
            s_cim_busy = 1'b0;
            if (w == 0) begin
                for (int k = 0; k < N; k++) s_data[k] = 8'(k + 100);
                #1;
                tests++;
                if (s_busy !== 1'b0) begin
                    $display("FAIL b2b_idle: busy=%b expected 0", s_busy);
                    fails++;
                end
                tick();
                s_start = 1'b0;
                #1;
                tests++;
                if (s_busy !== 1'b1 || s_we !== 1'b0) begin
                    $display("FAIL b2b_restart: busy=%b we=%b expected 1 0", s_busy, s_we);
                    fails++;
                end
                tick();
            end
        end
        s_start = 1'b0;
        #1;
        tests++;
        if (s_busy !== 1'b0) begin
            $display("FAIL b2b_end: busy=%b expected 0", s_busy);
            fails++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_wide();
        test_stall();
        test_fire_wait();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
